serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtracting counterpart of the team's ripple full-adder datapath. It sits beside the adder in the arithmetic unit, where area matters more than latency. Operands are accepted with a start/busy/done handshake, and the result is held until the next completion.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal range ≥ 2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; sampled with `start`.
- `b`  in  WIDTH  subtrahend; sampled with `start`.
- `bin`  in  1  borrow in; sampled with `start`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; result valid.
- `diff`  out  WIDTH  registered difference.
- `bout`  out  1  registered borrow out (1 = unsigned underflow).
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start`=1: load `a` and `b` into the shift registers.
  - Borrow flop ← `bin`; bit counter ← 0; go to SHIFT.
- **SHIFT** (one bit per edge), with `x` = `a_sr[0]`, `y` = `b_sr[0]`, `br` = borrow flop:
  - `d = x ^ y ^ br`.
  - `br_next = (~x & y) | (~x & br) | (y & br)`.
  - Shift `d` into the result register at the MSB; shift `a_sr` and `b_sr` right.
  - Counter increments each edge.
  - On the edge that processes bit WIDTH-1: `diff` ← final result register value, `bout` ← `br_next`, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` in SHIFT or DONE is ignored: no queuing, no restart.
- Operand inputs are don't-care outside the sampling edge.
- `diff`, `bout` and `ovf` change only at completion. They hold the previous result during SHIFT.
- Counter width is `$clog2(WIDTH)`; no wrap occurs before DONE.

## Timing
- Reset (async, immediate) clears the state to IDLE and drives `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0.
  - Shift registers, borrow flop and counter also clear.
- Reset mid-operation discards the in-flight operation; no `done` is produced for it.
- Edge E0 samples `start` in IDLE.
  - `busy`=1 from after E0 through edge E(WIDTH).
  - Result registered and `done`=1 after edge E(WIDTH).
  - `done` drops and the block returns to IDLE after E(WIDTH+1).
- Latency is WIDTH clocks from the sampling edge to `done`.
- Earliest next accepted `start` is at E(WIDTH+2). Throughput is one operation per WIDTH+2 clocks.
- `done` and `busy` are never high simultaneously.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined:**
  - `ovf` port exists.
  - At completion, `ovf` ← (borrow into bit WIDTH-1) XOR (`bout`), i.e. signed two's-complement overflow of `a - b - bin`.
  - Requires one extra flop to keep the borrow into the MSB.
  - Reset value 0; held like `diff`.
- **Undefined:**
  - `ovf` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- **Basic subtract:** `a`=0x35, `b`=0x12, `bin`=0, `start` at E0 → `diff`=0x23, `bout`=0, `done` high exactly one cycle after E8, `busy` high E0–E8.
- **Underflow:**
  - `a`=0x00, `b`=0x01, `bin`=0 → `diff`=0xFF, `bout`=1.
  - `a`=0x10, `b`=0x10, `bin`=1 → `diff`=0xFF, `bout`=1.
- **Start while busy:** op `a`=0x35, `b`=0x12, then `start` with `a`=0xFF, `b`=0x00 at E3 → single `done`, `diff`=0x23. `diff` holds its old value until E8.
- **Reset mid-op:** assert `rst` between E4 and E5 → `busy`, `done`, `diff`, `bout` = 0 immediately, no `done` follows. After release, `a`=0x09, `b`=0x04 → `diff`=0x05, `bout`=0.
- **Overflow** (`SERIAL_SUB_OVF_EN` defined):
  - 0x80 − 0x01 → `diff`=0x7F, `bout`=0, `ovf`=1.
  - 0x7F − 0xFF → `diff`=0x80, `bout`=1, `ovf`=1.
  - 0x05 − 0x03 → `ovf`=0.
- **Back-to-back:** `start` held high continuously → `done` pulses every 10 clocks, each result correct for the operands sampled at its accept edge.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, start/busy/done handshake.
// Optional signed overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             x, y, d, br_n;
  logic [WIDTH-1:0] res;
  assign x    = a_sr[0];
  assign y    = b_sr[0];
  assign d    = x ^ y ^ br;
  assign br_n = (~x & y) | (~x & br) | (y & br);
  assign res  = {d, r_sr};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          br    <= bin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= res[WIDTH-1:1];
          br   <= br_n;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= res;
            bout  <= br_n;
`ifdef SERIAL_SUB_OVF_EN
            // br here is the borrow into the MSB
            ovf   <= br ^ br_n;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif
  int vectors = 0;
  int errs = 0;
  logic [W-1:0] exp_diff = '0;
  logic         exp_bout = 1'b0;
  logic         exp_ovf = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    int sa, sb, s;
    logic [W:0] r;
    r  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    sa = $signed(ma);
    sb = $signed(mb);
    s  = sa - sb - int'(mbin);
    exp_diff = r[W-1:0];
    exp_bout = r[W];
    exp_ovf  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // One full operation; optionally a spurious start with other operands at E3.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input logic mid_start, input string tag);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_done_e0"}, 32'(done), 32'd0);
    start = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    for (int k = 1; k <= W; k++) begin
      if (mid_start && k == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      if (k == 4) start = 1'b0;
      if (k < W) check({tag, "_held"}, 32'(diff), 32'(exp_diff));
      @(posedge clk); #1;
      if (k < W) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_nodone"}, 32'(done), 32'd0);
      end
    end
    model(ta, tb, tbin);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_result(tag);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(8'h35, 8'h12, 1'b0, 1'b0, "basic");
    run_op(8'h00, 8'h01, 1'b0, 1'b0, "under1");
    run_op(8'h10, 8'h10, 1'b1, 1'b0, "under2");
    run_op(8'h35, 8'h12, 1'b0, 1'b1, "busy_start");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("no_restart", 32'(done | busy), 32'd0);
    end
    run_op(8'h80, 8'h01, 1'b0, 1'b0, "ovf1");
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0, "ovf2");
    run_op(8'h05, 8'h03, 1'b0, 1'b0, "ovf3");

    // Reset between E4 and E5.
    @(negedge clk);
    a = 8'hA7; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_done", 32'(done), 32'd0);
    check("rmid_diff", 32'(diff), 32'd0);
    check("rmid_bout", 32'(bout), 32'd0);
    exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("rmid_nodone", 32'(done), 32'd0);
    end
    run_op(8'h09, 8'h04, 1'b0, 1'b0, "after_rst");

    for (int k = 0; k < 20; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "rand");

    // Back-to-back: start held high, accepts every W+2 clocks.
    begin
      logic [W-1:0] qa, qb;
      logic         qbin;
      qa = '0; qb = '0; qbin = 1'b0;
      for (int c = 0; c < 5 * (W + 2); c++) begin
        @(negedge clk);
        a = $urandom; b = $urandom; bin = 1'($urandom); start = 1'b1;
        if (c % (W + 2) == 0) begin qa = a; qb = b; qbin = bin; end
        @(posedge clk); #1;
        check("b2b_done", 32'(done), 32'(c % (W + 2) == W));
        check("b2b_busy", 32'(busy), 32'(c % (W + 2) < W));
        if (c % (W + 2) == W) begin
          model(qa, qb, qbin);
          check_result("b2b");
        end
      end
      start = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
